// File: rtl/keypad_pkg.sv
// Keypad types and key-code map shared by the scanner and the alarm/time control FSM.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D
    function automatic logic [3:0] code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = KEY_A;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = KEY_B;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = KEY_C;
            4'b11_00: k = KEY_STAR;
            4'b11_01: k = 4'h0;
            4'b11_10: k = KEY_HASH;
            default:  k = KEY_D;
        endcase
        return k;
    endfunction

    function automatic logic single_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-ones (idle pulled-up lines).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row synchronise/debounce, one key_valid strobe per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned BW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] DEB_ONE    = BW'(1);

    kp_state_t      r_state;
    logic [1:0]     r_col;
    logic [3:0]     r_col_n;
    logic [DW-1:0]  r_dwell;
    logic [BW-1:0]  r_deb;
    logic [1:0]     r_row;
    logic [3:0]     r_key;
    logic           r_key_valid;
    logic           r_key_held;

    logic [3:0]     w_rs;
    logic           w_single;
    logic [1:0]     w_row_idx;
    logic           w_stable;
    logic           w_row_up;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (row_n),
        .o_q     (w_rs)
    );

    assign w_single  = single_low(w_rs);
    assign w_row_idx = low_index(w_rs);
    assign w_stable  = (w_rs == ~(4'b0001 << r_row));
    assign w_row_up  = w_rs[r_row];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SCAN;
            r_col       <= '0;
            r_col_n     <= 4'b1110;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_row       <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        // Multi-row lows are treated as ghosting and never captured
                        if (w_single) begin
                            r_row   <= w_row_idx;
                            r_deb   <= DEB_ONE;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col   <= r_col + 2'd1;
                            r_col_n <= {r_col_n[2:0], r_col_n[3]};
                        end
                    end else begin
                        r_dwell <= r_dwell + DWELL_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (w_stable && (r_deb == DEB_LAST)) begin
                        r_key       <= code(r_row, r_col);
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_deb       <= '0;
                        r_state     <= PRESSED;
                    end else if (w_stable) begin
                        r_deb <= r_deb + DEB_ONE;
                    end else begin
                        r_deb   <= '0;
                        r_col   <= r_col + 2'd1;
                        r_col_n <= {r_col_n[2:0], r_col_n[3]};
                        r_state <= SCAN;
                    end
                end
                PRESSED: begin
                    if (w_row_up) begin
                        r_deb   <= DEB_ONE;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_row_up) begin
                        r_deb   <= '0;
                        r_state <= PRESSED;
                    end else if (r_deb == DEB_LAST) begin
                        r_deb      <= '0;
                        r_key_held <= 1'b0;
                        r_col      <= r_col + 2'd1;
                        r_col_n    <= {r_col_n[2:0], r_col_n[3]};
                        r_state    <= SCAN;
                    end else begin
                        r_deb <= r_deb + DEB_ONE;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign col_n     = r_col_n;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    logic [3:0][3:0] pressed;   // pressed[row][col]
    logic            use_force;
    logic [3:0]      force_row;
    logic [3:0]      w_matrix;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_strobe = 0;
    int unsigned onehot_err = 0;
    logic        mon_en = 1'b0;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        w_matrix = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !col_n[c]) w_matrix[r] = 1'b0;
        row_n = use_force ? force_row : w_matrix;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(~col_n) != 1) onehot_err++;
            if (reset && key_valid) n_strobe++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int unsigned budget, output logic seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_held_low(input int unsigned budget, output logic seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (!key_held) seen = 1'b1;
        end
    endtask

    task automatic wait_col(input logic [3:0] val, input logic want_eq,
                            input int unsigned budget, output logic seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((col_n == val) == want_eq) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        seen;
        int unsigned e_cyc;
        int unsigned c0;
        int unsigned bad_col;
        int unsigned bad_held;
        int unsigned s0;
        int unsigned changes;
        logic [3:0]  prev_col;

        pressed   = '0;
        use_force = 1'b0;
        force_row = 4'b1111;
        reset     = 1'b1;

        // Reset and idle scan
        #2 reset = 1'b0;
        #1;
        mon_en = 1'b1;
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key", key, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("scan_col0_hold", col_n, 4'b1110);
        @(posedge clk);
        #1 check("scan_col1_after4", col_n, 4'b1101);
        repeat (12) @(posedge clk);
        #1 check("scan_wrap_after16", col_n, 4'b1110);

        // Key "5" held ~100 cycles
        pressed[1][1] = 1'b1;
        wait_col(4'b1101, 1'b1, 20, seen);
        check("k5_col1_reached", seen, 1'b1);
        e_cyc = cyc;
        wait_valid(40, seen);
        check("k5_strobe_seen", seen, 1'b1);
        check("k5_strobe_latency", cyc - e_cyc, 11);
        check("k5_key", key, 4'h5);
        check("k5_held", key_held, 1'b1);
        @(negedge clk);
        check("k5_strobe_single_cycle", key_valid, 1'b0);
        bad_col  = 0;
        bad_held = 0;
        for (int i = 0; i < 88; i++) begin
            @(negedge clk);
            if (col_n != 4'b1101) bad_col++;
            if (!key_held) bad_held++;
        end
        #1;
        check("k5_col_frozen", bad_col, 0);
        check("k5_held_during_press", bad_held, 0);
        check("k5_one_strobe", n_strobe, 1);
        c0 = cyc;
        pressed[1][1] = 1'b0;
        wait_held_low(30, seen);
        check("k5_release_seen", seen, 1'b1);
        check("k5_release_latency", cyc - c0, 10);
        check("k5_col_after_release", col_n, 4'b1011);

        // Key "#" with bounce
        s0 = n_strobe;
        for (int i = 0; i < 10; i++) begin
            pressed[3][2] = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        #1 check("hash_no_strobe_in_bounce", n_strobe, s0);
        pressed[3][2] = 1'b1;
        wait_valid(60, seen);
        check("hash_strobe_seen", seen, 1'b1);
        check("hash_key", key, 4'hF);
        pressed[3][2] = 1'b0;
        wait_held_low(40, seen);
        check("hash_release_seen", seen, 1'b1);
        #1 check("hash_one_strobe", n_strobe, s0 + 1);

        // 5-cycle glitch on row0/col0
        s0 = n_strobe;
        wait_col(4'b1110, 1'b0, 20, seen);
        wait_col(4'b1110, 1'b1, 20, seen);
        check("glitch_col0_reached", seen, 1'b1);
        e_cyc = cyc;
        pressed[0][0] = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_col_frozen", col_n, 4'b1110);
        pressed[0][0] = 1'b0;
        wait_col(4'b1110, 1'b0, 20, seen);
        check("glitch_resume_seen", seen, 1'b1);
        check("glitch_resume_col1", col_n, 4'b1101);
        check("glitch_resume_time", cyc - e_cyc, 8);
        repeat (10) @(negedge clk);
        #1;
        check("glitch_no_strobe", n_strobe, s0);
        check("glitch_key_kept", key, 4'hF);

        // Rows 0 and 2 low together: ghosting, never captured
        s0 = n_strobe;
        use_force = 1'b1;
        force_row = 4'b1010;
        @(negedge clk);
        prev_col = col_n;
        changes  = 0;
        bad_held = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (col_n != prev_col) changes++;
            if (key_held) bad_held++;
            prev_col = col_n;
        end
        #1;
        check("ghost_col_changes", changes, 16);
        check("ghost_never_held", bad_held, 0);
        check("ghost_no_strobe", n_strobe, s0);
        use_force = 1'b0;
        repeat (4) @(negedge clk);

        // Key "9" held across a reset
        pressed[2][2] = 1'b1;
        wait_valid(60, seen);
        check("k9_strobe_seen", seen, 1'b1);
        check("k9_key", key, 4'h9);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("k9_rst_col_n", col_n, 4'b1110);
        check("k9_rst_key", key, 4'h0);
        check("k9_rst_held", key_held, 1'b0);
        check("k9_rst_valid", key_valid, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s0 = n_strobe;
        wait_valid(80, seen);
        check("k9_restrobe_seen", seen, 1'b1);
        check("k9_restrobe_key", key, 4'h9);
        pressed[2][2] = 1'b0;
        wait_held_low(40, seen);
        check("k9_release_seen", seen, 1'b1);
        repeat (40) @(negedge clk);
        #1;
        check("k9_single_restrobe", n_strobe, s0 + 1);
        check("k9_key_kept", key, 4'h9);
        check("col_onehot_always", onehot_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
